pwm_pulse_determination: RTL and testbench
==========================================

// Module: pwm_pulse_determination
// PURPOSE
// - Consumer end of the 7-bit duty-cycle interface (0..64, 64 = 100%) driven by the waveform generators.
// - Turns the duty value into a single-bit PWM output: 64-step period, prescaled sysclk.
// - Duty is double-buffered (latched only at period boundaries) so mid-period changes never glitch.
// - Sits between the waveform source mux and the output pin / audio filter.
// PARAMETERS
// - DUTY_W      7    width of duty_in; legal values 0..FULL_SCALE
// - CNT_W       6    width of PWM period counter; period = 2**CNT_W steps
// - FULL_SCALE  64   duty value meaning 100% high; must equal 2**CNT_W
// - PRESCALE    4    sysclk cycles per PWM step; legal range 1..255
// PORTS
// - sysclk        in   1       system clock, all logic rising-edge
// - rst_n         in   1       asynchronous active-low reset
// - enable        in   1       run PWM; low = idle, output low
// - duty_in       in   DUTY_W  requested duty, sampled only at load points
// - clr_clip      in   1       synchronous clear of duty_clip
// - pwm_out       out  1       registered PWM output
// - period_start  out  1       1-sysclk strobe at each period start
// - duty_active   out  DUTY_W  duty currently in effect (shadow register)
// - duty_clip     out  1       sticky: a loaded duty_in exceeded FULL_SCALE
// BEHAVIOUR
// - Reset (async, rst_n low): all outputs 0; prescaler, step counter, shadow 0; run state IDLE.
// - Prescaler: counts 0..PRESCALE-1 while running; tick = (presc == PRESCALE-1). PRESCALE=1 -> tick every cycle.
// - Step counter cnt (CNT_W bits): increments on tick, wraps 63 -> 0; holds otherwise.
// - States: IDLE (enable=0) and RUN.
// - IDLE -> RUN on first cycle with enable=1: load shadow, cnt=0, presc=0, period_start=1 that cycle.
// - RUN -> IDLE when enable=0: counters cleared next cycle, pwm_out 0 next cycle; shadow holds its value.
// - Load points: RUN entry and each wrap (tick && cnt==63).
// - At a load point: shadow <= min(duty_in, FULL_SCALE).
// - If duty_in > FULL_SCALE at a load point, duty_clip <= 1.
// - duty_in is ignored outside load points.
// - period_start: 1 in the same cycle cnt becomes 0 (RUN entry or wrap); otherwise 0.
// - pwm_out registered: pwm_out <= RUN && (cnt_next < shadow_next), one sysclk after the state update,
//   so the new duty applies from step 0 of the new period.
// - Duty boundaries:
//   - 0  -> constantly low.
//   - 64 -> constantly high, no gap at wrap.
//   - 1  -> high exactly PRESCALE cycles per period.
//   - 63 -> low exactly PRESCALE cycles.
// - Period = 64*PRESCALE sysclk cycles. High time = shadow*PRESCALE cycles.
// - duty_clip: set has priority over clr_clip in the same cycle; cleared only by clr_clip or reset.
// - Reset mid-period: immediate return to reset values; first period after reset starts on enable.
// - enable toggled low/high within one period: restarts at step 0 with a fresh load (no partial period resumed).
// STRUCTURE
// - Shared package pwm_pkg:
//   - DUTY_W, CNT_W, FULL_SCALE constants
//   - function sat_duty(duty) returning min(duty, FULL_SCALE)
//   - run-state enum {IDLE, RUN}
// - Sub-module pwm_prescaler:
//   - parameter PRESCALE; ports sysclk, rst_n, clr, tick
//   - reused by the waveform generators' rate dividers.
// - Top holds step counter, shadow register, state, compare/output register, clip flag.
// TESTING
// - PRESCALE=1, enable=1, duty_in=32 -> pwm_out high 32 / low 32 cycles; period_start every 64 cycles.
// - duty_in=0 then 64 (changed mid-period) -> all-low until next period_start, then all-high with no low
//   cycle across following wraps; duty_active changes only at the boundary.
// - duty_in=100 -> duty_active=64, duty_clip=1 and stays set; pulse clr_clip -> 0; clr_clip in the same
//   cycle as a clipped load -> stays 1.
// - PRESCALE=4, duty_in=1 -> high 4 cycles per 256-cycle period; duty_in=63 -> low 4 cycles per period.
// - Drop enable at step 20, reassert 3 cycles later with duty_in=16 -> pwm_out 0 while idle;
//   period_start on re-enable; 16 high steps from step 0.
// - Assert rst_n=0 mid-high-phase -> pwm_out, duty_active, period_start, duty_clip all 0 immediately (async).

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: constants, run-state enum and duty saturation helper shared by the
// PWM output stage and the waveform generators that drive its duty interface.
//   DUTY_W      width of the duty interface (0..FULL_SCALE)
//   CNT_W       width of the PWM step counter, period = 2**CNT_W steps
//   FULL_SCALE  duty value meaning 100% high, equals 2**CNT_W
package pwm_pkg;

    localparam int DUTY_W     = 7;
    localparam int CNT_W      = 6;
    localparam int FULL_SCALE = 64;

    localparam logic [DUTY_W-1:0] FULL_SCALE_D = DUTY_W'(FULL_SCALE);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    // min(duty, FULL_SCALE)
    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] duty);
        return (duty > FULL_SCALE_D) ? FULL_SCALE_D : duty;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides sysclk into one tick every PRESCALE cycles.
//   sysclk  in   system clock
//   rst_n   in   asynchronous active-low reset
//   clr     in   synchronous clear, holds the count at 0
//   tick    out  high while the count sits at PRESCALE-1
// PRESCALE legal range 1..255; PRESCALE=1 gives a tick every cycle.
module pwm_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] presc;

    assign tick = (presc == LAST);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_pulse_determination.sv
// pwm_pulse_determination: turns a 0..FULL_SCALE duty value into a single-bit
// PWM output with a 2**CNT_W step period, each step PRESCALE sysclk cycles.
// The duty is double-buffered into a shadow register that only loads at the
// start of a period, so mid-period duty changes never glitch the output.
//   sysclk        in   system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   run PWM; low = idle with output low
//   duty_in       in   requested duty, sampled only at load points
//   clr_clip      in   synchronous clear of duty_clip
//   pwm_out       out  registered PWM output
//   period_start  out  1-cycle strobe in the cycle the step counter becomes 0
//   duty_active   out  duty currently in effect (shadow register)
//   duty_clip     out  sticky: a loaded duty_in exceeded FULL_SCALE
module pwm_pulse_determination
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              clr_clip,
    output logic              pwm_out,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_active,
    output logic              duty_clip
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    run_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DUTY_W-1:0] shadow, shadow_next;
    logic              tick, load, clr_presc, pwm_next;

    // Prescaler only counts while RUN persists; it sits at 0 through IDLE and
    // the entry cycle so step 0 of every period gets a full PRESCALE cycles.
    assign clr_presc = (state != RUN) || !enable;

    pwm_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .clr    (clr_presc),
        .tick   (tick)
    );

    // State register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter / shadow / compare logic. Load points are RUN entry and the
    // wrap out of the last step; both restart the period at step 0.
    always_comb begin
        load        = 1'b0;
        cnt_next    = cnt;
        shadow_next = shadow;
        case (state)
            IDLE: begin
                if (enable) begin
                    load     = 1'b1;
                    cnt_next = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    cnt_next = '0;
                end else if (tick) begin
                    cnt_next = cnt + 1'b1;
                    load     = (cnt == CNT_MAX);
                end
            end
            default: cnt_next = '0;
        endcase
        if (load) begin
            shadow_next = sat_duty(duty_in);
        end
        // Compare against the values being registered this edge so a new duty
        // takes effect from step 0 and duty=FULL_SCALE has no gap at the wrap.
        pwm_next = (state_next == RUN) && (DUTY_W'(cnt_next) < shadow_next);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            shadow       <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            duty_clip    <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            shadow       <= shadow_next;
            pwm_out      <= pwm_next;
            period_start <= load;
            // A clipped load wins over a same-cycle clear.
            if (load && (duty_in > FULL_SCALE_D)) begin
                duty_clip <= 1'b1;
            end else if (clr_clip) begin
                duty_clip <= 1'b0;
            end
        end
    end

    assign duty_active = shadow;

endmodule

// File: tb/tb_pwm_pulse_determination.sv
module tb_pwm_pulse_determination;

    logic            sysclk = 1'b0;
    logic            rst_n;
    logic [1:0]      enable;
    logic [6:0]      duty_in;
    logic            clr_clip;
    logic [1:0]      pwm_out;
    logic [1:0]      period_start;
    logic [1:0][6:0] duty_active;
    logic [1:0]      duty_clip;

    int errs   = 0;
    int checks = 0;

    // One expected period: checked at its period_start (duty, clip) and when it
    // closes (high cycles, length, whether the next period follows directly).
    typedef struct {
        int k;
        int id;
        int duty;
        int clip;
        int high;
        int len;
        int cont;
    } rec_t;

    rec_t sb[$];

    always #5 sysclk = ~sysclk;

    pwm_pulse_determination #(.PRESCALE(1)) dut0 (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .enable       (enable[0]),
        .duty_in      (duty_in),
        .clr_clip     (clr_clip),
        .pwm_out      (pwm_out[0]),
        .period_start (period_start[0]),
        .duty_active  (duty_active[0]),
        .duty_clip    (duty_clip[0])
    );

    pwm_pulse_determination #(.PRESCALE(4)) dut1 (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .enable       (enable[1]),
        .duty_in      (duty_in),
        .clr_clip     (clr_clip),
        .pwm_out      (pwm_out[1]),
        .period_start (period_start[1]),
        .duty_active  (duty_active[1]),
        .duty_clip    (duty_clip[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic push(input int k, input int id, input int duty, input int clip,
                        input int high, input int len, input int cont);
        rec_t r;
        r.k = k; r.id = id; r.duty = duty; r.clip = clip;
        r.high = high; r.len = len; r.cont = cont;
        sb.push_back(r);
    endtask

    // Returns at the falling edge of the cycle in which period_start is seen.
    task automatic wait_ps(input int k, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge sysclk);
            seen = period_start[k];
        end
        chk($sformatf("wait period_start k=%0d", k), int'(seen), 1);
    endtask

    task automatic mon(input int k);
        rec_t e;
        bit   open = 1'b0;
        bit   ok;
        int   hi = 0;
        int   n  = 0;
        forever begin
            @(negedge sysclk);
            if (!rst_n) begin
                open = 1'b0;
            end else begin
                if (open && (period_start[k] || n == e.len)) begin
                    chk($sformatf("p%0d.high", e.id), hi, e.high);
                    chk($sformatf("p%0d.len", e.id), n, e.len);
                    if (n == e.len)
                        chk($sformatf("p%0d.next_start", e.id), int'(period_start[k]), e.cont);
                    open = 1'b0;
                end
                if (period_start[k]) begin
                    ok = (sb.size() > 0) ? (sb[0].k == k) : 1'b0;
                    chk($sformatf("expected period_start k=%0d", k), int'(ok), 1);
                    if (ok) begin
                        e = sb.pop_front();
                        chk($sformatf("p%0d.duty_active", e.id), int'(duty_active[k]), e.duty);
                        chk($sformatf("p%0d.duty_clip", e.id), int'(duty_clip[k]), e.clip);
                        open = 1'b1;
                        hi   = 0;
                        n    = 0;
                    end
                end
                if (open) begin
                    hi += int'(pwm_out[k]);
                    n++;
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 2'b00;
        duty_in  = 7'd0;
        clr_clip = 1'b0;
        #3;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset.pwm_out%0d", k), int'(pwm_out[k]), 0);
            chk($sformatf("reset.period_start%0d", k), int'(period_start[k]), 0);
            chk($sformatf("reset.duty_active%0d", k), int'(duty_active[k]), 0);
            chk($sformatf("reset.duty_clip%0d", k), int'(duty_clip[k]), 0);
        end
        step(2);
        rst_n = 1'b1;
        step(2);

        // PRESCALE=1: 50% duty, two back-to-back periods
        duty_in = 7'd32;
        push(0, 1, 32, 0, 32, 64, 1);
        push(0, 2, 32, 0, 32, 64, 1);
        enable[0] = 1'b1;
        wait_ps(0, 4);
        wait_ps(0, 70);
        // duty 0 requested mid-period, applies from next period
        step(10);
        duty_in = 7'd0;
        push(0, 3, 0, 0, 0, 64, 1);
        wait_ps(0, 70);
        step(20);
        duty_in = 7'd64;
        push(0, 4, 64, 0, 64, 64, 1);
        push(0, 5, 64, 0, 64, 64, 1);
        step(1);
        chk("p3.duty_hold", int'(duty_active[0]), 0);
        wait_ps(0, 70);
        wait_ps(0, 70);
        // out-of-range duty saturates and sets the sticky flag
        step(10);
        duty_in = 7'd100;
        push(0, 6, 64, 1, 64, 64, 1);
        wait_ps(0, 70);
        step(5);
        clr_clip = 1'b1;
        step(1);
        clr_clip = 1'b0;
        chk("clr_clip", int'(duty_clip[0]), 0);
        // clear in the same cycle as a clipped load: set wins
        push(0, 7, 64, 1, 64, 64, 1);
        step(57);
        clr_clip = 1'b1;
        step(1);
        clr_clip = 1'b0;
        wait_ps(0, 2);
        step(10);
        chk("clip_sticky", int'(duty_clip[0]), 1);
        // enable dropped at step 20 for 3 cycles, restarts with duty 16
        duty_in = 7'd40;
        push(0, 8, 40, 1, 21, 24, 1);
        wait_ps(0, 70);
        step(20);
        enable[0] = 1'b0;
        step(1);
        chk("idle_low", int'(pwm_out[0]), 0);
        duty_in = 7'd16;
        step(2);
        enable[0] = 1'b1;
        push(0, 9, 16, 1, 16, 64, 0);
        wait_ps(0, 4);
        step(63);
        enable[0] = 1'b0;
        step(4);

        // PRESCALE=4: duty 1 then 63
        duty_in = 7'd1;
        push(1, 11, 1, 0, 4, 256, 1);
        push(1, 12, 1, 0, 4, 256, 1);
        enable[1] = 1'b1;
        wait_ps(1, 4);
        wait_ps(1, 260);
        step(50);
        duty_in = 7'd63;
        push(1, 13, 63, 0, 252, 256, 0);
        wait_ps(1, 260);
        step(255);
        enable[1] = 1'b0;
        step(4);

        // asynchronous reset in the middle of the high phase
        duty_in = 7'd48;
        push(0, 20, 48, 1, 48, 64, 1);
        enable[0] = 1'b1;
        wait_ps(0, 4);
        step(10);
        chk("prereset_high", int'(pwm_out[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.pwm_out", int'(pwm_out[0]), 0);
        chk("async.duty_active", int'(duty_active[0]), 0);
        chk("async.period_start", int'(period_start[0]), 0);
        chk("async.duty_clip", int'(duty_clip[0]), 0);
        enable[0] = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("post_reset.pwm_out", int'(pwm_out[0]), 0);
        chk("post_reset.duty_active", int'(duty_active[0]), 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
